// File: rtl/iob_cache_write_channel_buf.sv
// iob_cache_write_channel_buf
//   Buffered cache back-end write channel. Front-end writes are queued in a
//   2**BUF_DEPTH_W entry FIFO and drained to the native back-end interface by
//   a two-state (IDLE/BUSY) FSM, so the cache only stalls on a full buffer.
//   WRITE_POL=0 (write-through): one BE word per entry with byte strobes.
//   WRITE_POL=1 (write-back): one cache line per entry, drained as a burst.
//
// Optional feature macro: IOB_CACHE_WCH_COALESCE_EN
//   Write-through only. A write hitting the tail entry's BE word (with the tail
//   distinct from the head being presented) is merged into the tail.
//
// Ports:
//   clk_i, reset_n_i        clock (rising edge), asynchronous active-low reset
//   valid_i/ready_o         front-end write handshake
//   addr_i                  word address (WT) or line address (WB)
//   wstrb_i                 byte strobes (WT only)
//   wdata_i                 write word (WT) or full line (WB)
//   empty_o                 FIFO empty and no transfer in flight
//   full_o                  FIFO holds all entries
//   be_addr_o/be_valid_o    back-end request (BE-aligned byte address)
//   be_ack_i                back-end completes current beat
//   be_wdata_o/be_wstrb_o   back-end write data and byte strobes
module iob_cache_write_channel_buf #(
  parameter int ADDR_W        = 24,
  parameter int FE_DATA_W     = 32,
  parameter int BE_ADDR_W     = 24,
  parameter int BE_DATA_W     = 32,
  parameter int WORD_OFFSET_W = 3,
  parameter int WRITE_POL     = 0,
  parameter int BUF_DEPTH_W   = 2
) (
  input  logic                                                              clk_i,
  input  logic                                                              reset_n_i,
  input  logic                                                              valid_i,
  input  logic [ADDR_W-$clog2(FE_DATA_W/8)-WRITE_POL*WORD_OFFSET_W-1:0]     addr_i,
  input  logic [FE_DATA_W/8-1:0]                                            wstrb_i,
  input  logic [FE_DATA_W*(2**(WORD_OFFSET_W*WRITE_POL))-1:0]               wdata_i,
  output logic                                                              ready_o,
  output logic                                                              empty_o,
  output logic                                                              full_o,
  output logic [BE_ADDR_W-1:0]                                              be_addr_o,
  output logic                                                              be_valid_o,
  input  logic                                                              be_ack_i,
  output logic [BE_DATA_W-1:0]                                              be_wdata_o,
  output logic [BE_DATA_W/8-1:0]                                            be_wstrb_o
);

  localparam int FE_NBYTES   = FE_DATA_W / 8;
  localparam int FE_NBYTES_W = $clog2(FE_NBYTES);
  localparam int BE_NBYTES   = BE_DATA_W / 8;
  localparam int BE_NBYTES_W = $clog2(BE_NBYTES);
  localparam int RATIO_W     = $clog2(BE_DATA_W / FE_DATA_W);
  localparam int IN_ADDR_W   = ADDR_W - FE_NBYTES_W - WRITE_POL * WORD_OFFSET_W;
  localparam int IN_DATA_W   = FE_DATA_W * (2 ** (WORD_OFFSET_W * WRITE_POL));
  localparam int DEPTH       = 2 ** BUF_DEPTH_W;
  localparam int ENT_A_W     = (WRITE_POL != 0) ? IN_ADDR_W : ADDR_W - BE_NBYTES_W;
  localparam int ENT_D_W     = (WRITE_POL != 0) ? IN_DATA_W : BE_DATA_W;
  localparam int EXT_W       = (BE_ADDR_W > ADDR_W) ? BE_ADDR_W : ADDR_W;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 r_state, w_state_nxt;
  logic [BUF_DEPTH_W-1:0] r_wr_ptr, r_rd_ptr, w_tail, w_mem_idx;
  logic [BUF_DEPTH_W:0]   r_count, w_count_nxt;
  logic [ENT_A_W-1:0]     r_mem_addr [DEPTH];
  logic [ENT_D_W-1:0]     r_mem_data [DEPTH];

  logic                   w_full, w_merge_hit, w_accept, w_push, w_merge;
  logic                   w_be_valid, w_ack, w_pop, w_last_beat;
  logic [ENT_A_W-1:0]     w_in_addr;
  logic [ENT_D_W-1:0]     w_in_data, w_merged_data;
  logic [ADDR_W-1:0]      w_be_byte_addr;
  logic [EXT_W-1:0]       w_addr_ext;
  logic [BE_NBYTES-1:0]   w_head_strb;
  logic [BE_DATA_W-1:0]   w_head_wdata;

  // Handshake and FIFO control
  assign w_full      = r_count[BUF_DEPTH_W];
  assign ready_o     = ~w_full | w_merge_hit;
  assign w_accept    = valid_i & ready_o;
  assign w_push      = w_accept & ~w_merge_hit;
  assign w_merge     = w_accept & w_merge_hit;
  assign w_ack       = w_be_valid & be_ack_i;
  assign w_pop       = w_ack & w_last_beat;
  assign w_count_nxt = r_count + (BUF_DEPTH_W+1)'(w_push) - (BUF_DEPTH_W+1)'(w_pop);
  assign w_tail      = r_wr_ptr - BUF_DEPTH_W'(1);
  assign w_mem_idx   = w_push ? r_wr_ptr : w_tail;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + BUF_DEPTH_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + BUF_DEPTH_W'(1);
      r_count <= w_count_nxt;
    end
  end

  // Entry storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (w_push || w_merge) begin
      r_mem_addr[w_mem_idx] <= w_in_addr;
      r_mem_data[w_mem_idx] <= w_push ? w_in_data : w_merged_data;
    end
  end

  if (WRITE_POL == 0) begin : g_wt
    logic [BE_NBYTES-1:0] r_mem_strb [DEPTH];
    logic [BE_NBYTES-1:0] w_in_strb;

    if (RATIO_W > 0) begin : g_align
      logic [RATIO_W-1:0] w_word_align;
      assign w_word_align = addr_i[RATIO_W-1:0];
      assign w_in_addr    = addr_i[IN_ADDR_W-1:RATIO_W];
      assign w_in_strb    = BE_NBYTES'(wstrb_i) << (int'(w_word_align) * FE_NBYTES);
    end else begin : g_noalign
      assign w_in_addr = addr_i;
      assign w_in_strb = wstrb_i;
    end

    assign w_in_data = {(BE_DATA_W / FE_DATA_W){wdata_i}};

`ifdef IOB_CACHE_WCH_COALESCE_EN
    // count >= 2 guarantees the tail is not the entry on the back-end bus.
    assign w_merge_hit = valid_i & (r_count > (BUF_DEPTH_W+1)'(1))
                       & (r_mem_addr[w_tail] == w_in_addr);
    always_comb begin
      w_merged_data = r_mem_data[w_tail];
      for (int unsigned b = 0; b < BE_NBYTES; b++)
        if (w_in_strb[b]) w_merged_data[b*8 +: 8] = w_in_data[b*8 +: 8];
    end
`else
    assign w_merge_hit   = 1'b0;
    assign w_merged_data = w_in_data;
`endif

    always_ff @(posedge clk_i) begin
      if (w_push)       r_mem_strb[r_wr_ptr] <= w_in_strb;
      else if (w_merge) r_mem_strb[w_tail]   <= r_mem_strb[w_tail] | w_in_strb;
    end

    assign w_head_strb    = r_mem_strb[r_rd_ptr];
    assign w_head_wdata   = r_mem_data[r_rd_ptr];
    assign w_be_byte_addr = {r_mem_addr[r_rd_ptr], {BE_NBYTES_W{1'b0}}};
    assign w_last_beat    = 1'b1;
  end else begin : g_wb
    localparam int LINE2BE_W = WORD_OFFSET_W - RATIO_W;
    logic [ENT_D_W-1:0] w_head_line;

    assign w_in_addr     = addr_i;
    assign w_in_data     = wdata_i;
    assign w_merged_data = w_in_data;
    assign w_merge_hit   = 1'b0;
    assign w_head_strb   = '1;
    assign w_head_line   = r_mem_data[r_rd_ptr];

    if (LINE2BE_W > 0) begin : g_beats
      logic [LINE2BE_W-1:0] r_beat;
      // Wraps to zero on the last beat, which is also when the entry pops.
      always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)  r_beat <= '0;
        else if (w_ack)  r_beat <= r_beat + LINE2BE_W'(1);
      end
      assign w_last_beat    = &r_beat;
      assign w_head_wdata   = w_head_line[r_beat*BE_DATA_W +: BE_DATA_W];
      assign w_be_byte_addr = {r_mem_addr[r_rd_ptr], r_beat, {BE_NBYTES_W{1'b0}}};
    end else begin : g_single
      assign w_last_beat    = 1'b1;
      assign w_head_wdata   = w_head_line;
      assign w_be_byte_addr = {r_mem_addr[r_rd_ptr], {BE_NBYTES_W{1'b0}}};
    end
  end

  // Drain FSM: state register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= IDLE;
    else            r_state <= w_state_nxt;
  end

  // Drain FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (r_count != '0) w_state_nxt = BUSY;
      BUSY:    if (w_pop && (w_count_nxt == '0)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Drain FSM: outputs
  always_comb begin
    w_be_valid = (r_state == BUSY);
  end

  assign w_addr_ext = EXT_W'(w_be_byte_addr);
  assign be_addr_o  = w_addr_ext[BE_ADDR_W-1:0];
  assign be_valid_o = w_be_valid;
  assign be_wdata_o = w_head_wdata;
  assign be_wstrb_o = w_be_valid ? w_head_strb : '0;
  assign empty_o    = (r_count == '0) && (r_state == IDLE);
  assign full_o     = w_full;

endmodule
